// File: rtl/debounce_pkg.sv
// Shared defaults and a constant-width helper for the button debouncer.
package debounce_pkg;

    localparam int          DEFAULT_CNT_W        = 16;
    localparam logic [23:0] DEFAULT_REPEAT_DELAY = 24'd5_000_000;
    localparam logic [23:0] DEFAULT_REPEAT_RATE  = 24'd1_000_000;

    // ceil(log2(v)); used to size counters from parameters
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-FF sync, stable-time filter, press/release edge pulses and
// optional hold-to-repeat pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int          CNT_W        = DEFAULT_CNT_W,
    parameter int          ACTIVE_LOW   = 1,
    parameter int          REPEAT_EN    = 0,
    parameter logic [23:0] REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter logic [23:0] REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic state,
    output logic down,
    output logic up,
    output logic rpt,
    output logic down_next
);

    logic             level;
    logic             s0, s1;
    logic [CNT_W-1:0] cnt;
    logic             flip;
    logic             up_next;

    assign level     = (ACTIVE_LOW != 0) ? ~raw : raw;
    assign flip      = (s1 != state) && (&cnt);
    assign down_next = flip && !state;
    assign up_next   = flip && state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0    <= 1'b0;
            s1    <= 1'b0;
            cnt   <= '0;
            state <= 1'b0;
            down  <= 1'b0;
            up    <= 1'b0;
        end else begin
            s0 <= level;
            s1 <= s0;
            // any agreement restarts the window; a full window of mismatch flips
            if (s1 == state) begin
                cnt <= '0;
            end else if (&cnt) begin
                cnt   <= '0;
                state <= ~state;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            down <= down_next;
            up   <= up_next;
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_rpt
            localparam int unsigned RPT_MAX =
                32'((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
            localparam int RPT_W = clog2(RPT_MAX + 1);
            localparam logic [RPT_W-1:0] DLY_M1  = RPT_W'(REPEAT_DELAY - 24'd1);
            localparam logic [RPT_W-1:0] RATE_M1 = RPT_W'(REPEAT_RATE - 24'd1);

            logic [RPT_W-1:0] rpt_cnt;
            logic             first;
            logic             rpt_q;
            logic [RPT_W-1:0] target;

            assign target = first ? DLY_M1 : RATE_M1;
            assign rpt    = rpt_q;

            // counter reloads on every tick, so it never exceeds the larger interval
            always_ff @(posedge clk) begin
                if (!rst_n || !state || up_next) begin
                    rpt_cnt <= '0;
                    first   <= 1'b1;
                    rpt_q   <= 1'b0;
                end else if (rpt_cnt == target) begin
                    rpt_cnt <= '0;
                    first   <= 1'b0;
                    rpt_q   <= 1'b1;
                end else begin
                    rpt_cnt <= rpt_cnt + RPT_W'(1);
                    rpt_q   <= 1'b0;
                end
            end
        end else begin : g_no_rpt
            assign rpt = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multi_button_debouncer.sv
// N independent debounced buttons; adds a combined press pulse aligned with pb_down.
module multi_button_debouncer
    import debounce_pkg::*;
#(
    parameter int          N_CH         = 4,
    parameter int          CNT_W        = DEFAULT_CNT_W,
    parameter int          ACTIVE_LOW   = 1,
    parameter int          REPEAT_EN    = 0,
    parameter logic [23:0] REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter logic [23:0] REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pb_raw,
    output logic [N_CH-1:0] pb_state,
    output logic [N_CH-1:0] pb_down,
    output logic [N_CH-1:0] pb_up,
    output logic [N_CH-1:0] pb_repeat,
    output logic            any_down
);

    logic [N_CH-1:0] down_next;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            debounce_channel #(
                .CNT_W       (CNT_W),
                .ACTIVE_LOW  (ACTIVE_LOW),
                .REPEAT_EN   (REPEAT_EN),
                .REPEAT_DELAY(REPEAT_DELAY),
                .REPEAT_RATE (REPEAT_RATE)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .raw      (pb_raw[i]),
                .state    (pb_state[i]),
                .down     (pb_down[i]),
                .up       (pb_up[i]),
                .rpt      (pb_repeat[i]),
                .down_next(down_next[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) any_down <= 1'b0;
        else        any_down <= |down_next;
    end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench: window 16, repeat delay 40 / rate 10, active-low buttons.
module tb_multi_button_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pb_raw;
    logic [3:0] pb_state, pb_down, pb_up, pb_repeat;
    logic       any_down;

    int checks = 0;
    int errors = 0;
    int dn_cnt [4];
    int up_cnt [4];
    int rp_cnt [4];

    multi_button_debouncer #(
        .N_CH(4), .CNT_W(4), .ACTIVE_LOW(1), .REPEAT_EN(1),
        .REPEAT_DELAY(24'd40), .REPEAT_RATE(24'd10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pb_raw(pb_raw), .pb_state(pb_state),
        .pb_down(pb_down), .pb_up(pb_up), .pb_repeat(pb_repeat), .any_down(any_down)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) begin
            dn_cnt[i] = 0; up_cnt[i] = 0; rp_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pb_down[i])   dn_cnt[i]++;
            if (pb_up[i])     up_cnt[i]++;
            if (pb_repeat[i]) rp_cnt[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind: 0 = pb_down, 1 = pb_up; n = ticks taken (max on timeout)
    task automatic wait_bit(input int ch, input int kind, input int max, output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < max) begin
            tick();
            n++;
            seen = (kind == 0) ? pb_down[ch] : pb_up[ch];
        end
        if (!seen) n = max;
    endtask

    initial begin
        int n;
        int d0, u0, r0;
        logic exp_r;

        // 1: reset with all buttons released
        rst_n  = 1'b0;
        pb_raw = 4'hF;
        repeat (5) tick();
        chk("reset_outputs", {pb_state, pb_down, pb_up, pb_repeat, any_down}, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("idle_outputs", {pb_state, pb_down, pb_up, pb_repeat, any_down}, 0);
        end

        // 2: clean press / release on ch0
        r0 = rp_cnt[0];
        pb_raw[0] = 1'b0;
        wait_bit(0, 0, 40, n);
        chk("ch0_down_latency", (n >= 17 && n <= 19), 1);
        chk("ch0_down_vec", pb_down, 4'b0001);
        chk("ch0_state_on", pb_state, 4'b0001);
        chk("ch0_any_down", any_down, 1);
        tick();
        chk("ch0_down_once", {pb_down, any_down}, 0);
        chk("ch0_state_hold", pb_state, 4'b0001);
        pb_raw[0] = 1'b1;
        wait_bit(0, 1, 40, n);
        chk("ch0_up_latency", (n >= 17 && n <= 19), 1);
        chk("ch0_up_vec", pb_up, 4'b0001);
        chk("ch0_state_off", pb_state, 4'b0000);
        tick();
        chk("ch0_up_once", pb_up, 0);
        chk("ch0_no_repeat", rp_cnt[0] - r0, 0);

        // 3: bounce on ch1 then settle low
        d0 = dn_cnt[1];
        u0 = up_cnt[1];
        r0 = rp_cnt[1];
        for (int t = 0; t < 20; t++) begin
            pb_raw[1] = ~pb_raw[1];
            repeat (5) begin
                tick();
                chk("bounce_state", pb_state[1], 0);
            end
        end
        chk("bounce_no_pulse", (dn_cnt[1] - d0) + (up_cnt[1] - u0), 0);
        pb_raw[1] = 1'b0;
        wait_bit(1, 0, 40, n);
        chk("ch1_settle_latency", (n >= 16 && n <= 19), 1);
        repeat (10) tick();
        chk("ch1_single_down", dn_cnt[1] - d0, 1);
        pb_raw[1] = 1'b1;
        wait_bit(1, 1, 40, n);
        chk("ch1_up_latency", (n >= 17 && n <= 19), 1);
        chk("ch1_no_repeat", rp_cnt[1] - r0, 0);

        // 4: hold ch2 for repeats; release lands on a would-be repeat tick (+100)
        r0 = rp_cnt[2];
        pb_raw[2] = 1'b0;
        wait_bit(2, 0, 40, n);
        chk("ch2_down_latency", (n >= 17 && n <= 19), 1);
        for (int k = 1; k <= 110; k++) begin
            tick();
            exp_r = (k >= 40 && k <= 90 && (k % 10) == 0);
            chk("ch2_repeat", pb_repeat[2], exp_r);
            chk("ch2_up", pb_up[2], (k == 100));
            chk("ch2_no_down", pb_down[2], 0);
            if (k == 82) pb_raw[2] = 1'b1;
        end
        chk("ch2_repeat_count", rp_cnt[2] - r0, 6);

        // 5: simultaneous press on ch0 and ch3
        pb_raw = 4'b0110;
        wait_bit(0, 0, 40, n);
        chk("sim_latency", (n >= 17 && n <= 19), 1);
        chk("sim_down_vec", pb_down, 4'b1001);
        chk("sim_any_down", any_down, 1);
        tick();
        chk("sim_down_clear", {pb_down, any_down}, 0);
        pb_raw = 4'hF;
        wait_bit(0, 1, 40, n);
        chk("sim_up_vec", pb_up, 4'b1001);

        // 6: reset in the middle of ch1's window
        pb_raw[1] = 1'b0;
        repeat (12) tick();
        chk("mid_window_state", pb_state[1], 0);
        rst_n = 1'b0;
        tick();
        chk("mid_reset_outputs", {pb_state, pb_down, pb_up, pb_repeat, any_down}, 0);
        tick();
        chk("mid_reset_outputs2", {pb_state, pb_down, pb_up, pb_repeat, any_down}, 0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_quiet", {pb_state, pb_down, pb_up, pb_repeat, any_down}, 0);
        wait_bit(1, 0, 40, n);
        chk("post_reset_latency", (n + 1 >= 17 && n + 1 <= 19), 1);
        chk("post_reset_down", pb_down, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
